// File: rtl/addsub_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    localparam int DEFAULT_DIGIT = 4;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/cla_digit.sv
// One DIGIT-wide carry-lookahead slice: per-bit propagate/generate cells,
// lookahead carry chain, sum bits and group propagate/generate.
module cla_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             gp,
    output logic             gg
);

    logic [DIGIT-1:0] p;
    logic [DIGIT-1:0] g;
    logic [DIGIT:0]   c;

    assign p = a ^ b;
    assign g = a & b;

    always_comb begin
        c[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

    // Group terms let the caller form the slice carry without the bit chain.
    always_comb begin
        gg = 1'b0;
        for (int i = 0; i < DIGIT; i++) begin
            gg = g[i] | (p[i] & gg);
        end
    end

    assign gp   = &p;
    assign sum  = p ^ c[DIGIT-1:0];
    assign cout = c[DIGIT];

endmodule

// File: rtl/serial_addsub32.sv
// Digit-serial WIDTH-bit adder/subtractor, DIGIT bits per clock, start/busy/done handshake.
// Optional ov/zero flags are built when ADDSUB_FLAGS_EN is defined.
module serial_addsub32
    import addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = DEFAULT_DIGIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co
`ifdef ADDSUB_FLAGS_EN
    ,
    output logic             ov,
    output logic             zero
`endif
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? clog2(N) : 1;

    state_t           state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [DIGIT-1:0] dsum;
    logic             dcout;
    logic             dgp;
    logic             dgg;
    logic [WIDTH-1:0] sum_full;

    cla_digit #(.DIGIT(DIGIT)) u_digit (
        .a    (opa[DIGIT-1:0]),
        .b    (opb[DIGIT-1:0]),
        .cin  (carry),
        .sum  (dsum),
        .cout (dcout),
        .gp   (dgp),
        .gg   (dgg)
    );

    // Result as it will look once the current (final) digit is shifted in.
    assign sum_full = {dsum, acc[WIDTH-1:DIGIT]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            opa   <= '0;
            opb   <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            s     <= '0;
            co    <= 1'b0;
`ifdef ADDSUB_FLAGS_EN
            ov    <= 1'b0;
            zero  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_FIN: begin
                    done <= 1'b0;
                    if (start) begin
                        opa   <= a;
                        opb   <= b ^ {WIDTH{sub}};
                        carry <= sub;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    acc   <= sum_full;
                    opa   <= opa >> DIGIT;
                    opb   <= opb >> DIGIT;
                    carry <= dgg | (dgp & carry);
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(N - 1)) begin
                        s     <= sum_full;
                        co    <= dcout;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_FIN;
`ifdef ADDSUB_FLAGS_EN
                        // Carry into the MSB recovered from its sum bit and operand bits.
                        ov    <= (dsum[DIGIT-1] ^ opa[DIGIT-1] ^ opb[DIGIT-1]) ^ dcout;
                        zero  <= (sum_full == '0);
`endif
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub32.sv
// Directed self-checking bench for serial_addsub32 (flag checks active with ADDSUB_FLAGS_EN).
module tb_serial_addsub32;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] s;
    logic        co;
    logic        ov;
    logic        zero;

    int n_checks;
    int n_fail;

    serial_addsub32 #(.WIDTH(32), .DIGIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .co    (co)
`ifdef ADDSUB_FLAGS_EN
        ,
        .ov    (ov),
        .zero  (zero)
`endif
    );

`ifndef ADDSUB_FLAGS_EN
    assign ov   = 1'b0;
    assign zero = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one operation and return the number of edges from accept to done (-1 on timeout).
    task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic isub,
                          output int lat);
        @(negedge clk);
        a = ia; b = ib; sub = isub; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        #12;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        n_checks++; if (s !== 32'h0) begin n_fail++; $display("FAIL reset_s got=%h exp=0", s); end
        n_checks++; if (co !== 1'b0) begin n_fail++; $display("FAIL reset_co got=%b exp=0", co); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        int lat;
        run_op(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, lat);
        n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL add_latency got=%0d exp=8", lat); end
        n_checks++; if (s !== 32'h0) begin n_fail++; $display("FAIL add_s got=%h exp=00000000", s); end
        n_checks++; if (co !== 1'b1) begin n_fail++; $display("FAIL add_co got=%b exp=1", co); end
`ifdef ADDSUB_FLAGS_EN
        n_checks++; if (zero !== 1'b1) begin n_fail++; $display("FAIL add_zero got=%b exp=1", zero); end
        n_checks++; if (ov !== 1'b0) begin n_fail++; $display("FAIL add_ov got=%b exp=0", ov); end
`endif
        @(posedge clk);
        #1;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL add_done_pulse got=%b exp=0", done); end
        run_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, lat);
        n_checks++; if (s !== 32'hACF1_3568) begin n_fail++; $display("FAIL add_mixed_s got=%h exp=acf13568", s); end
        n_checks++; if (co !== 1'b0) begin n_fail++; $display("FAIL add_mixed_co got=%b exp=0", co); end
    endtask

    task automatic test_sub();
        int lat;
        run_op(32'h0000_0005, 32'h0000_0007, 1'b1, lat);
        n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL sub_latency got=%0d exp=8", lat); end
        n_checks++; if (s !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL sub_s got=%h exp=fffffffe", s); end
        n_checks++; if (co !== 1'b0) begin n_fail++; $display("FAIL sub_co got=%b exp=0", co); end
`ifdef ADDSUB_FLAGS_EN
        n_checks++; if (ov !== 1'b0) begin n_fail++; $display("FAIL sub_ov got=%b exp=0", ov); end
        n_checks++; if (zero !== 1'b0) begin n_fail++; $display("FAIL sub_zero got=%b exp=0", zero); end
`endif
        run_op(32'h0000_1234, 32'h0000_0000, 1'b1, lat);
        n_checks++; if (s !== 32'h0000_1234) begin n_fail++; $display("FAIL sub_b0_s got=%h exp=00001234", s); end
        n_checks++; if (co !== 1'b1) begin n_fail++; $display("FAIL sub_b0_co got=%b exp=1", co); end
    endtask

    task automatic test_overflow();
        int lat;
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, lat);
        n_checks++; if (s !== 32'h8000_0000) begin n_fail++; $display("FAIL ovf_add_s got=%h exp=80000000", s); end
        n_checks++; if (co !== 1'b0) begin n_fail++; $display("FAIL ovf_add_co got=%b exp=0", co); end
`ifdef ADDSUB_FLAGS_EN
        n_checks++; if (ov !== 1'b1) begin n_fail++; $display("FAIL ovf_add_ov got=%b exp=1", ov); end
`endif
        run_op(32'h8000_0000, 32'h0000_0001, 1'b1, lat);
        n_checks++; if (s !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL ovf_sub_s got=%h exp=7fffffff", s); end
        n_checks++; if (co !== 1'b1) begin n_fail++; $display("FAIL ovf_sub_co got=%b exp=1", co); end
`ifdef ADDSUB_FLAGS_EN
        n_checks++; if (ov !== 1'b1) begin n_fail++; $display("FAIL ovf_sub_ov got=%b exp=1", ov); end
`endif
    endtask

    task automatic test_busy_ignore();
        int cyc;
        int busy_after;
        @(negedge clk);
        a = 32'h0000_0100; b = 32'h0000_0023; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (i == 3) begin
                a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; sub = 1'b1; start = 1'b1;
            end
            if (i == 4) start = 1'b0;
            if (done) begin
                cyc = i;
                break;
            end
        end
        n_checks++; if (cyc !== 8) begin n_fail++; $display("FAIL busy_ign_latency got=%0d exp=8", cyc); end
        n_checks++; if (s !== 32'h0000_0123) begin n_fail++; $display("FAIL busy_ign_s got=%h exp=00000123", s); end
        n_checks++; if (co !== 1'b0) begin n_fail++; $display("FAIL busy_ign_co got=%b exp=0", co); end
        busy_after = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (busy || done) busy_after++;
        end
        n_checks++; if (busy_after !== 0) begin n_fail++; $display("FAIL busy_ign_queued got=%0d exp=0", busy_after); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] op_a [3];
        logic [31:0] op_b [3];
        logic        op_s [3];
        logic [31:0] exp_s [3];
        logic        exp_c [3];
        int nd, cyc, last, stable_bad, both_bad;
        op_a[0] = 32'h1111_1111; op_b[0] = 32'h2222_2222; op_s[0] = 1'b0;
        exp_s[0] = 32'h3333_3333; exp_c[0] = 1'b0;
        op_a[1] = 32'h0000_0000; op_b[1] = 32'h0000_0001; op_s[1] = 1'b1;
        exp_s[1] = 32'hFFFF_FFFF; exp_c[1] = 1'b0;
        op_a[2] = 32'hFFFF_FFFF; op_b[2] = 32'hFFFF_FFFF; op_s[2] = 1'b0;
        exp_s[2] = 32'hFFFF_FFFE; exp_c[2] = 1'b1;
        @(negedge clk);
        a = op_a[0]; b = op_b[0]; sub = op_s[0]; start = 1'b1;
        @(posedge clk);
        #1;
        nd = 0; cyc = 0; last = -1; stable_bad = 0; both_bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done && busy) both_bad++;
            if (done) begin
                n_checks++; if (s !== exp_s[nd]) begin n_fail++; $display("FAIL b2b_s[%0d] got=%h exp=%h", nd, s, exp_s[nd]); end
                n_checks++; if (co !== exp_c[nd]) begin n_fail++; $display("FAIL b2b_co[%0d] got=%b exp=%b", nd, co, exp_c[nd]); end
                n_checks++; if ((cyc - last) !== ((nd == 0) ? 9 : 9)) begin n_fail++; $display("FAIL b2b_spacing[%0d] got=%0d exp=9", nd, cyc - last); end
                last = cyc;
                nd++;
                if (nd == 3) begin
                    start = 1'b0;
                    break;
                end
                a = op_a[nd]; b = op_b[nd]; sub = op_s[nd];
            end else if (nd > 0 && s !== exp_s[nd-1]) begin
                stable_bad++;
            end
        end
        n_checks++; if (nd !== 3) begin n_fail++; $display("FAIL b2b_count got=%0d exp=3", nd); end
        n_checks++; if (stable_bad !== 0) begin n_fail++; $display("FAIL b2b_stable got=%0d exp=0", stable_bad); end
        n_checks++; if (both_bad !== 0) begin n_fail++; $display("FAIL b2b_done_busy got=%0d exp=0", both_bad); end
        start = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int done_seen;
        @(negedge clk);
        a = 32'hAAAA_AAAA; b = 32'h5555_5555; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        n_checks++; if (s !== 32'h0) begin n_fail++; $display("FAIL rst_mid_s got=%h exp=0", s); end
        n_checks++; if (co !== 1'b0) begin n_fail++; $display("FAIL rst_mid_co got=%b exp=0", co); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) done_seen++;
        end
        n_checks++; if (done_seen !== 0) begin n_fail++; $display("FAIL rst_mid_no_done got=%0d exp=0", done_seen); end
        run_op(32'h0000_0003, 32'h0000_0004, 1'b0, lat);
        n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL rst_mid_next_latency got=%0d exp=8", lat); end
        n_checks++; if (s !== 32'h0000_0007) begin n_fail++; $display("FAIL rst_mid_next_s got=%h exp=00000007", s); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_add();
        test_sub();
        test_overflow();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
